// File: rtl/phase_scheduler.sv
// Four-approach intersection phase scheduler: round-robin green with min/max green, yellow and all-red.
// Emergency preemption is compiled in only when PHASE_SCHED_EC_EN is defined.
module phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ec,
  input  logic [1:0] ec_dir,
  output logic [3:0] grant,
  output logic [7:0] light,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED_T - 1);

  state_t        state, state_n;
  logic [1:0]    cur, cur_n, ptr, ptr_n, picked;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    grant_n;
  logic [7:0]    light_n;
  logic          other, leave, ec_on;

`ifdef PHASE_SCHED_EC_EN
  assign ec_on = ec;
`else
  logic unused_ec;
  assign ec_on     = 1'b0;
  assign unused_ec = ec;
`endif

  // First requester after ptr; the smallest offset wins, ptr itself is scanned last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign picked = pick(req, ptr);
  assign other  = |(req & ~(4'b0001 << cur));

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    leave   = 1'b0;
    case (state)
      IDLE, ALLRED: begin
        if (state == IDLE || cnt == AR_LAST) begin
          if (ec_on) begin
            state_n = GREEN;
            cur_n   = ec_dir;
            ptr_n   = ec_dir;
          end else if (|req) begin
            state_n = GREEN;
            cur_n   = picked;
            ptr_n   = picked;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GREEN: begin
        leave = ((cnt >= GMIN_LAST) && !req[cur]) || ((cnt >= GMAX_LAST) && other);
        // An active emergency overrides the timers: yield unless we are the emergency approach.
        if (ec_on) leave = (cur != ec_dir);
        if (leave) state_n = YELLOW;
      end
      YELLOW: begin
        if (cnt == Y_LAST) state_n = ALLRED;
      end
      default: state_n = IDLE;
    endcase

    cnt_n = (state_n != state) ? '0 : ((&cnt) ? cnt : cnt + CW'(1));

    grant_n = '0;
    light_n = '0;
    if (state_n == GREEN) begin
      grant_n = 4'b0001 << cur_n;
      light_n = 8'b0000_0010 << {cur_n, 1'b0};
    end else if (state_n == YELLOW) begin
      light_n = 8'b0000_0001 << {cur_n, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 2'd0;
      ptr   <= 2'd3;
      cnt   <= '0;
      grant <= 4'd0;
      light <= 8'h00;
      phase <= 2'd0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      grant <= grant_n;
      light <= light_n;
      phase <= state_n;
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: expected output runs (value and length) are queued by
// the stimulus and compared by a monitor whenever the DUT output changes.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ec;
  logic [1:0] ec_dir;
  logic [3:0] grant;
  logic [7:0] light;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [13:0] v;
    int          len;
  } run_t;

  run_t        exp_q[$];
  logic [13:0] run_v;
  int          run_len = 0;
  bit          started = 1'b0;

  logic [7:0] green_light[4]  = '{8'h02, 8'h08, 8'h20, 8'h80};
  logic [7:0] yellow_light[4] = '{8'h01, 8'h04, 8'h10, 8'h40};
  logic [3:0] grant_bits[4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  phase_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ec     (ec),
    .ec_dir (ec_dir),
    .grant  (grant),
    .light  (light),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Drive inputs at a falling edge, then hold them for n falling edges.
  task automatic applyStimulus(input logic [3:0] r, input logic e, input logic [1:0] d, input int n);
    req    = r;
    ec     = e;
    ec_dir = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [13:0] act_v, input int act_len,
                             input logic [13:0] exp_v, input int exp_len);
    checks++;
    if (act_v !== exp_v || act_len != exp_len) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b light=%h phase=%0d len=%0d, expected grant=%b light=%h phase=%0d len=%0d",
               name, act_v[13:10], act_v[9:2], act_v[1:0], act_len,
               exp_v[13:10], exp_v[9:2], exp_v[1:0], exp_len);
    end
  endtask

  task automatic expectRun(input string name, input logic [13:0] v, input int len);
    run_t e;
    e.name = name;
    e.v    = v;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // One full service of approach i: green for glen cycles, 3 yellow, 2 all-red.
  task automatic expectCycle(input int i, input int glen);
    expectRun($sformatf("green%0d", i),  {grant_bits[i], green_light[i], 2'd1}, glen);
    expectRun($sformatf("yellow%0d", i), {4'b0000, yellow_light[i], 2'd2}, 3);
    expectRun($sformatf("allred%0d", i), {4'b0000, 8'h00, 2'd3}, 2);
  endtask

  // Monitor: a run ends when the sampled output changes; compare it with the next queued run.
  initial begin
    logic [13:0] sample;
    run_t        e;
    forever begin
      @(negedge clk);
      sample = {grant, light, phase};
      if (started && sample === run_v) begin
        run_len++;
      end else begin
        if (started) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_run: got grant=%b light=%h phase=%0d len=%0d, expected no further change",
                     run_v[13:10], run_v[9:2], run_v[1:0], run_len);
          end else begin
            e = exp_q.pop_front();
            checkOutput(e.name, run_v, run_len, e.v, e.len);
          end
        end
        run_v   = sample;
        run_len = 1;
        started = 1'b1;
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got no completion by time %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    req    = 4'b0001;
    ec     = 1'b0;
    ec_dir = 2'd0;

    expectRun("reset_hold", 14'h0, 3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {grant, light, phase}, 0, 14'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Lone request holds green far past GREEN_MAX, then a competitor forces clearance.
    expectRun("green0_long", {4'b0001, 8'h02, 2'd1}, 20);
    expectRun("yellow0", {4'b0000, 8'h01, 2'd2}, 3);
    expectRun("allred0", {4'b0000, 8'h00, 2'd3}, 2);
    applyStimulus(4'b0001, 1'b0, 2'd0, 20);
    expectCycle(2, 10);
    applyStimulus(4'b0101, 1'b0, 2'd0, 6);

    // All approaches requesting: max-green rotation 3, 0, 1 after approach 2.
    expectCycle(3, 10);
    expectCycle(0, 10);
    expectCycle(1, 10);
    applyStimulus(4'b1111, 1'b0, 2'd0, 55);

    // Short pulse: exactly GREEN_MIN of green, then back to idle.
    expectRun("idle_a", 14'h0, 4);
    expectCycle(1, 4);
    expectRun("idle_b", 14'h0, 3);
    applyStimulus(4'b0000, 1'b0, 2'd0, 8);
    applyStimulus(4'b0010, 1'b0, 2'd0, 1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 11);

    // Emergency toward approach 3 while approach 1 is green at cnt=1.
`ifdef PHASE_SCHED_EC_EN
    expectCycle(1, 2);
    expectCycle(3, 31);
`else
    expectCycle(1, 38);
`endif
    applyStimulus(4'b0010, 1'b0, 2'd0, 2);
    applyStimulus(4'b0010, 1'b1, 2'd3, 36);

    // Reset pulse in the middle of a yellow, then restart from ptr=3.
    expectRun("idle_c", 14'h0, 3);
    expectRun("green0_short", {4'b0001, 8'h02, 2'd1}, 4);
    expectRun("yellow0_cut", {4'b0000, 8'h01, 2'd2}, 2);
    expectRun("reset_pulse", 14'h0, 1);
    expectCycle(3, 4);
    applyStimulus(4'b0000, 1'b0, 2'd0, 8);
    applyStimulus(4'b0001, 1'b0, 2'd0, 1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 5);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", {grant, light, phase}, 0, 14'h0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    repeat (14) @(negedge clk);

    checkOutput("final_idle", {grant, light, phase}, 0, 14'h0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_runs: got %0d runs still queued, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
